// File: rtl/ibex_dbus_router.sv
// Routes the Ibex LSU data port to NumDev memory-mapped targets with in-order responses.
// Optional response watchdog and stale-response filtering: define DBUS_TIMEOUT_EN.
module ibex_dbus_router #(
   parameter int unsigned          NumDev         = 2,
   parameter logic [32*NumDev-1:0] DevBase        = {32'h8000_0000, 32'h0010_0000},
   parameter logic [32*NumDev-1:0] DevMask        = {32'hFFFF_0000, 32'hFFF0_0000},
   parameter int unsigned          MaxOutstanding = 2,
   parameter int unsigned          TimeoutCycles  = 255
) (
   input  logic                     clk_sys_i,
   input  logic                     rst_sys_ni,
   input  logic                     host_req_i,
   output logic                     host_gnt_o,
   input  logic                     host_we_i,
   input  logic [3:0]               host_be_i,
   input  logic [31:0]              host_addr_i,
   input  logic [31:0]              host_wdata_i,
   output logic                     host_rvalid_o,
   output logic [31:0]              host_rdata_o,
   output logic                     host_err_o,
   output logic [NumDev-1:0]        dev_req_o,
   input  logic [NumDev-1:0]        dev_gnt_i,
   output logic                     dev_we_o,
   output logic [3:0]               dev_be_o,
   output logic [31:0]              dev_addr_o,
   output logic [31:0]              dev_wdata_o,
   input  logic [NumDev-1:0]        dev_rvalid_i,
   input  logic [32*NumDev-1:0]     dev_rdata_i,
   input  logic [NumDev-1:0]        dev_err_i
);
   localparam int unsigned TagW = 3;
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [TagW-1:0] TagErr = TagW'(NumDev);

   if (NumDev < 1 || NumDev > 4 || MaxOutstanding < 1 || TimeoutCycles < 1) begin : g_bad_cfg
      $error("ibex_dbus_router: unsupported parameter set");
   end

   logic [TagW-1:0]   fifo_q [MaxOutstanding];
   logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]   count_q;
   logic [TagW-1:0]   tail_q, sel_tag, head_tag;
   logic [NumDev-1:0] sel_oh, head_oh, stale_nz, swallow;
   logic              sel_is_err, head_is_err, head_is_dev, blocked, fire, push, pop;
   logic              dev_resp, tmo, head_err;
   logic [31:0]       head_rdata;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reverse scan so the lowest-index hit is the one left standing.
   always_comb begin
      sel_oh  = '0;
      sel_tag = TagErr;
      for (int i = NumDev - 1; i >= 0; i--) begin
         if ((host_addr_i & DevMask[32*i +: 32]) == DevBase[32*i +: 32]) begin
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_tag   = TagW'(i);
         end
      end
   end

   assign sel_is_err  = (sel_tag == TagErr);
   assign head_tag    = fifo_q[rd_ptr_q];
   assign head_is_err = (count_q != '0) && (head_tag == TagErr);
   assign head_is_dev = (count_q != '0) && (head_tag != TagErr);

   always_comb begin
      head_oh    = '0;
      head_rdata = '0;
      head_err   = 1'b0;
      for (int i = 0; i < NumDev; i++) begin
         if ((count_q != '0) && (head_tag == TagW'(i))) begin
            head_oh[i] = 1'b1;
            head_rdata = dev_rdata_i[32*i +: 32];
            head_err   = dev_err_i[i];
         end
      end
   end

   // Only one target may have live traffic at a time, which keeps responses in issue order.
   assign blocked = (count_q == CntW'(MaxOutstanding)) ||
                    ((count_q != '0) && (tail_q != sel_tag)) ||
                    (|(sel_oh & stale_nz));
   assign fire    = host_req_i & ~blocked & rst_sys_ni;

   assign host_gnt_o = fire & (sel_is_err | (|(dev_gnt_i & sel_oh)));
   assign dev_req_o  = fire ? sel_oh : '0;
   assign push       = host_gnt_o;

   assign dev_we_o    = host_we_i;
   assign dev_be_o    = host_be_i;
   assign dev_addr_o  = host_addr_i;
   assign dev_wdata_o = host_wdata_i;

   assign dev_resp      = |(dev_rvalid_i & ~swallow & head_oh);
   assign pop           = head_is_err | dev_resp | tmo;
   assign host_rvalid_o = pop;
   assign host_rdata_o  = dev_resp ? head_rdata : 32'h0;
   assign host_err_o    = head_is_err | tmo | (dev_resp & head_err);

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         tail_q   <= TagErr;
         for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= TagErr;
      end else begin
         count_q <= count_q + CntW'(push) - CntW'(pop);
         if (push) begin
            fifo_q[wr_ptr_q] <= sel_tag;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
            tail_q           <= sel_tag;
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

`ifdef DBUS_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
   logic [TmoW-1:0]             tmo_cnt_q, tmo_cnt_d;
   logic [NumDev-1:0][CntW-1:0] stale_q, stale_d;

   // A swallowed rvalid belongs to an abandoned transaction, so the head keeps waiting.
   assign swallow = dev_rvalid_i & stale_nz;
   assign tmo     = head_is_dev & ~dev_resp & (tmo_cnt_q == TmoW'(TimeoutCycles - 1));

   always_comb begin
      stale_nz  = '0;
      stale_d   = stale_q;
      tmo_cnt_d = tmo_cnt_q;
      if (pop) tmo_cnt_d = '0;
      else if (head_is_dev) tmo_cnt_d = tmo_cnt_q + 1'b1;
      for (int i = 0; i < NumDev; i++) begin
         stale_nz[i] = (stale_q[i] != '0);
         stale_d[i]  = stale_q[i] + CntW'(tmo & head_oh[i]) - CntW'(swallow[i]);
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         tmo_cnt_q <= '0;
         stale_q   <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         stale_q   <= stale_d;
      end
   end
`else
   assign stale_nz = '0;
   assign swallow  = '0;
   assign tmo      = 1'b0;
`endif

   assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      (dev_rvalid_i & ~(head_oh | stale_nz)) == '0)
      else $error("ibex_dbus_router: rvalid from a device with no outstanding request");

endmodule
